// File: rtl/upb_tcam_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : upb_tcam_pkg
//  Brief    : Shared types and SRL truth-table helper for the TCAM entry logic
//  Revision : 1.0
// ============================================================================
package upb_tcam_pkg;

  // Widest SRL address supported (SRL_SIZE up to 32)
  localparam int SRL_ADDR_MAX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One truth-table bit: does SRL address 'addr' satisfy the ternary slice?
  function automatic logic srl_bit(
    input logic [SRL_ADDR_MAX_W-1:0] addr,
    input logic [SRL_ADDR_MAX_W-1:0] value_slice,
    input logic [SRL_ADDR_MAX_W-1:0] mask_slice,
    input logic                      clear
  );
    return clear ? 1'b0
                 : (((addr ^ value_slice) & mask_slice) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/upb_tcam_entry_writer.sv
`default_nettype none
// ============================================================================
//  Module   : upb_tcam_entry_writer
//  Brief    : Serialises a ternary rule into one TCAM entry's SRL write port
//  Revision : 1.0
// ============================================================================
module upb_tcam_entry_writer
  import upb_tcam_pkg::*;
#(
  parameter  int SRL_SIZE   = 32,
  parameter  int TCAM_WIDTH = 2,
  localparam int KEY_BITS   = $clog2(SRL_SIZE),
  localparam int KEY_W      = KEY_BITS * TCAM_WIDTH,
  localparam int SLICE_W    = (TCAM_WIDTH > 1) ? $clog2(TCAM_WIDTH) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [KEY_W-1:0]   cmd_value,
  input  logic [KEY_W-1:0]   cmd_mask,
  input  logic               cmd_clear,
  output logic               wdata,
  output logic [SLICE_W-1:0] waddr,
  output logic               wen,
  output logic               busy,
  output logic               done
);

  localparam logic [KEY_BITS-1:0] C_BIT_LAST   = KEY_BITS'(SRL_SIZE - 1);
  localparam logic [SLICE_W-1:0]  C_SLICE_LAST = SLICE_W'(TCAM_WIDTH - 1);

  state_t              r_state,  w_state_n;
  logic [KEY_BITS-1:0] r_bit,    w_bit_n;
  logic [SLICE_W-1:0]  r_slice,  w_slice_n;
  logic [KEY_W-1:0]    r_value,  w_value_n;
  logic [KEY_W-1:0]    r_mask,   w_mask_n;
  logic                r_clear,  w_clear_n;
  logic                r_wen,    w_wen_n;
  logic                r_wdata,  w_wdata_n;
  logic                r_busy,   w_busy_n;
  logic                r_done,   w_done_n;
  logic                r_ready,  w_ready_n;
  logic [KEY_BITS-1:0] w_val_slice;
  logic [KEY_BITS-1:0] w_msk_slice;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_slice <= '0;
      r_value <= '0;
      r_mask  <= '0;
      r_clear <= 1'b0;
      r_wen   <= 1'b0;
      r_wdata <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_bit   <= w_bit_n;
      r_slice <= w_slice_n;
      r_value <= w_value_n;
      r_mask  <= w_mask_n;
      r_clear <= w_clear_n;
      r_wen   <= w_wen_n;
      r_wdata <= w_wdata_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_ready <= w_ready_n;
    end
  end

  // Counters always name the bit being presented on wdata/waddr this cycle,
  // so the next-state logic computes the bit for the position it moves to.
  always_comb begin
    w_state_n   = r_state;
    w_bit_n     = r_bit;
    w_slice_n   = r_slice;
    w_value_n   = r_value;
    w_mask_n    = r_mask;
    w_clear_n   = r_clear;
    w_wen_n     = 1'b0;
    w_busy_n    = 1'b0;
    w_done_n    = 1'b0;
    w_ready_n   = 1'b0;
    w_wdata_n   = 1'b0;
    w_val_slice = '0;
    w_msk_slice = '0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_ready) begin
          w_state_n = ST_SHIFT;
          w_bit_n   = C_BIT_LAST;
          w_slice_n = C_SLICE_LAST;
          w_value_n = cmd_value;
          w_mask_n  = cmd_mask;
          w_clear_n = cmd_clear;
          w_wen_n   = 1'b1;
          w_busy_n  = 1'b1;
        end else begin
          w_ready_n = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_bit == '0 && r_slice == '0) begin
          w_state_n = ST_DONE;
          w_done_n  = 1'b1;
        end else begin
          w_wen_n  = 1'b1;
          w_busy_n = 1'b1;
          if (r_bit == '0) begin
            w_bit_n   = C_BIT_LAST;
            w_slice_n = r_slice - 1'b1;
          end else begin
            w_bit_n = r_bit - 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_ready_n = 1'b1;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_ready_n = 1'b1;
      end
    endcase

    w_val_slice = w_value_n[int'(w_slice_n) * KEY_BITS +: KEY_BITS];
    w_msk_slice = w_mask_n[int'(w_slice_n) * KEY_BITS +: KEY_BITS];
    w_wdata_n   = w_wen_n & srl_bit(SRL_ADDR_MAX_W'(w_bit_n),
                                    SRL_ADDR_MAX_W'(w_val_slice),
                                    SRL_ADDR_MAX_W'(w_msk_slice),
                                    w_clear_n);
  end

  assign cmd_ready = r_ready;
  assign wdata     = r_wdata;
  assign waddr     = r_slice;
  assign wen       = r_wen;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_upb_tcam_entry_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_upb_tcam_entry_writer
//  Brief    : Directed + random bench; captures the SRL stream into a model
//             entry and sweeps every key against the ternary rule.
//  Revision : 1.0
// ============================================================================
module tb_upb_tcam_entry_writer;

  localparam int SS  = 32;
  localparam int TW  = 2;
  localparam int A   = 5;
  localparam int W   = A * TW;
  localparam int NSH = SS * TW;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_value = '0;
  logic [W-1:0] cmd_mask  = '0;
  logic         cmd_clear = 1'b0;
  logic         wdata;
  logic [0:0]   waddr;
  logic         wen;
  logic         busy;
  logic         done;

  upb_tcam_entry_writer #(.SRL_SIZE(SS), .TCAM_WIDTH(TW)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_value(cmd_value), .cmd_mask(cmd_mask), .cmd_clear(cmd_clear),
    .wdata(wdata), .waddr(waddr), .wen(wen), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [SS-1:0] srl [TW];
  int nwen, bad_addr, bad_ctl, done_at, ones;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the falling edge of the first wen cycle; returns at the done cycle.
  task automatic collect();
    int exp_addr;
    nwen = 0; bad_addr = 0; bad_ctl = 0; done_at = -1; ones = 0;
    for (int s = 0; s < TW; s++) srl[s] = '0;
    for (int cyc = 0; cyc < 4 * NSH; cyc++) begin
      if (done === 1'b1) begin
        done_at = cyc;
        if (busy !== 1'b0 || wen !== 1'b0 || cmd_ready !== 1'b0) bad_ctl++;
        break;
      end
      if (wen === 1'b1) begin
        exp_addr = TW - 1 - nwen / SS;
        if (int'(waddr) != exp_addr) bad_addr++;
        srl[waddr] = {srl[waddr][SS-2:0], wdata};
        if (wdata === 1'b1) ones++;
        nwen++;
      end else begin
        bad_ctl++;
      end
      if (busy !== 1'b1 || cmd_ready !== 1'b0) bad_ctl++;
      @(negedge CLK);
    end
    chk("wen_cycles", 64'(nwen), 64'(NSH));
    chk("done_latency", 64'(done_at), 64'(NSH));
    chk("waddr_seq", 64'(bad_addr), 64'd0);
    chk("ctl_during_seq", 64'(bad_ctl), 64'd0);
  endtask

  // Look up every key in the captured entry and compare with the ternary rule.
  task automatic sweep(input string tag, input logic [W-1:0] v, input logic [W-1:0] m,
                       input logic clr);
    int bad;
    logic got, exp;
    bad = 0;
    for (int c = 0; c < (1 << W); c++) begin
      got = 1'b1;
      for (int s = 0; s < TW; s++) got &= srl[s][(c >> (s * A)) & (SS - 1)];
      exp = !clr && ((((c ^ int'(v)) & int'(m)) & ((1 << W) - 1)) == 0);
      if (got !== exp) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic do_cmd(input string tag, input logic [W-1:0] v, input logic [W-1:0] m,
                        input logic clr);
    @(negedge CLK);
    cmd_value = v; cmd_mask = m; cmd_clear = clr; cmd_valid = 1'b1;
    chk("ready_before_accept", 64'(cmd_ready), 64'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_value = W'($urandom);
    cmd_mask  = W'($urandom);
    cmd_clear = 1'($urandom);
    collect();
    sweep(tag, v, m, clr);
    @(negedge CLK);
    chk("ready_after_done", 64'(cmd_ready), 64'd1);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] rv, rm, va, vb;
    logic         rc;

    repeat (3) @(negedge CLK);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wen",   64'(wen),       64'd0);
    chk("rst_wdata", 64'(wdata),     64'd0);
    chk("rst_waddr", 64'(waddr),     64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    RST = 1'b0;

    // Exact match: slice 1 one-hot at 21, slice 0 one-hot at 5
    do_cmd("exact_sweep", 10'h2A5, 10'h3FF, 1'b0);
    chk("exact_srl1", 64'(srl[1]), 64'h0020_0000);
    chk("exact_srl0", 64'(srl[0]), 64'h0000_0020);

    do_cmd("wild_sweep", 10'h155, 10'h000, 1'b0);
    chk("wild_ones", 64'(ones), 64'(NSH));

    do_cmd("partial_sweep", 10'h000, 10'h3E0, 1'b0);

    do_cmd("clear_sweep", 10'h2A5, 10'h3FF, 1'b1);
    chk("clear_ones", 64'(ones), 64'd0);

    // Back-to-back with cmd_valid held and value changing mid-sequence
    va = 10'h1C3; vb = 10'h07E;
    @(negedge CLK);
    cmd_value = va; cmd_mask = 10'h3FF; cmd_clear = 1'b0; cmd_valid = 1'b1;
    chk("b2b_ready0", 64'(cmd_ready), 64'd1);
    @(negedge CLK);
    cmd_value = vb;
    collect();
    sweep("b2b_first_sweep", va, 10'h3FF, 1'b0);
    @(negedge CLK);
    chk("b2b_ready1", 64'(cmd_ready), 64'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_value = 10'h3FF;
    collect();
    sweep("b2b_second_sweep", vb, 10'h3FF, 1'b0);
    @(negedge CLK);
    chk("b2b_idle", 64'(cmd_ready), 64'd1);

    // Reset on wen cycle 20
    @(negedge CLK);
    cmd_value = 10'h0F0; cmd_mask = 10'h3FF; cmd_clear = 1'b0; cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (19) @(negedge CLK);
    chk("midrst_wen_before", 64'(wen), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_wen",   64'(wen),       64'd0);
    chk("midrst_busy",  64'(busy),      64'd0);
    chk("midrst_done",  64'(done),      64'd0);
    chk("midrst_ready", 64'(cmd_ready), 64'd1);
    do_cmd("after_rst_sweep", 10'h2A5, 10'h3FF, 1'b0);

    // Reset wins over a simultaneous command
    @(negedge CLK);
    RST = 1'b1; cmd_valid = 1'b1; cmd_value = 10'h111; cmd_mask = 10'h3FF;
    @(negedge CLK);
    RST = 1'b0; cmd_valid = 1'b0;
    chk("rstwin_wen",   64'(wen),       64'd0);
    chk("rstwin_busy",  64'(busy),      64'd0);
    chk("rstwin_ready", 64'(cmd_ready), 64'd1);
    @(negedge CLK);
    chk("rstwin_wen_later", 64'(wen), 64'd0);

    // Random rules
    for (int i = 0; i < 8; i++) begin
      rv = W'($urandom);
      rm = W'($urandom) & W'($urandom);
      rc = ($urandom_range(0, 7) == 0);
      do_cmd("rand_sweep", rv, rm, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
